svc_soc_uart_tx_fifo: RTL and testbench

// Byte FIFO between the SoC MMIO UART data-register write strobe and svc_uart_tx.

---
 rtl/svc_soc_io_pkg.sv | 15 +
 rtl/svc_soc_uart_tx_fifo.sv | 69 ++++++
 tb/tb_svc_soc_uart_tx_fifo.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/svc_soc_io_pkg.sv
// Shared SoC MMIO constants: register offsets within the IO window and
// status-register bit positions for the UART TX path.
package svc_soc_io_pkg;

   localparam logic [7:0] IO_UART_TX_OFF   = 8'h00;
   localparam logic [7:0] IO_UART_STAT_OFF = 8'h04;
   localparam logic [7:0] IO_LED_OFF       = 8'h08;
   localparam logic [7:0] IO_GPIO_OFF      = 8'h0C;

   // STAT_TX_READY reads as !full
   localparam int unsigned STAT_TX_READY = 0;
   localparam int unsigned STAT_TX_EMPTY = 1;
   localparam int unsigned STAT_TX_OVF   = 2;

endpackage

// File: rtl/svc_soc_uart_tx_fifo.sv
// Byte FIFO between the UART TX data-register write strobe and svc_uart_tx.
// First-word-fall-through read side; sticky overflow when pushing into a full FIFO.
module svc_soc_uart_tx_fifo
   import svc_soc_io_pkg::*;
#(
   parameter  int unsigned DEPTH      = 16,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   input  logic                  ovf_clr,
   output logic                  utx_valid,
   output logic [7:0]            utx_data,
   input  logic                  utx_ready
);

   localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

   logic [7:0]          mem_q [DEPTH];
   logic [ADDR_WIDTH:0] wr_ptr_q, rd_ptr_q;
   logic                overflow_q;
   logic                push, pop;

   // Extra pointer MSB distinguishes full from empty when the indices match
   assign count     = wr_ptr_q - rd_ptr_q;
   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign overflow  = overflow_q;
   assign utx_valid = !empty;
   assign utx_data  = empty ? 8'h00 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

   assign push = wr_en && !full;
   assign pop  = utx_valid && utx_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         // A dropped push outranks a clear landing in the same cycle
         if (wr_en && full) begin
            overflow_q <= 1'b1;
         end else if (ovf_clr) begin
            overflow_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_svc_soc_uart_tx_fifo.sv
// Directed bench for svc_soc_uart_tx_fifo: reset, burst, fill/overflow,
// full+pop corner, randomised wrap against a queue model, push latency.
module tb_svc_soc_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       ovf_clr;
   logic       utx_valid;
   logic [7:0] utx_data;
   logic       utx_ready;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   svc_soc_uart_tx_fifo #(.DEPTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr),
      .utx_valid (utx_valid),
      .utx_data  (utx_data),
      .utx_ready (utx_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic test_reset();
      logic [16:0] exp_v;
      exp_v = {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00};
      rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0; utx_ready = 1'b0;
      #1;
      tests++;
      if ({full, empty, count, utx_valid, overflow, utx_data} !== exp_v) begin
         fails++;
         $display("FAIL reset_init: got %h want %h",
                  {full, empty, count, utx_valid, overflow, utx_data}, exp_v);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_burst();
      utx_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
      tests++;
      if (count !== 5'd4) begin
         fails++; $display("FAIL burst_count: got %0d want 4", count);
      end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (utx_valid !== 1'b1 || utx_data !== 8'h41) begin
            fails++;
            $display("FAIL burst_hold: valid %b data %h want 1 41", utx_valid, utx_data);
         end
         tick();
      end
      utx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (utx_valid !== 1'b1 || utx_data !== 8'h41 + 8'(i)) begin
            fails++;
            $display("FAIL burst_order[%0d]: valid %b data %h want 1 %h",
                     i, utx_valid, utx_data, 8'h41 + 8'(i));
         end
         tick();
      end
      utx_ready = 1'b0;
      tests++;
      if (empty !== 1'b1 || utx_valid !== 1'b0) begin
         fails++; $display("FAIL burst_empty: empty %b valid %b want 1 0", empty, utx_valid);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
      tests++;
      if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL fill_full: full %b count %0d ovf %b want 1 16 0", full, count, overflow);
      end
      push(8'hFF);
      tests++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         fails++; $display("FAIL fill_ovf: ovf %b count %0d want 1 16", overflow, count);
      end
      utx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tests++;
         if (utx_valid !== 1'b1 || utx_data !== 8'h10 + 8'(i)) begin
            fails++;
            $display("FAIL fill_drain[%0d]: valid %b data %h want 1 %h",
                     i, utx_valid, utx_data, 8'h10 + 8'(i));
         end
         tick();
      end
      utx_ready = 1'b0;
      tests++;
      if (empty !== 1'b1) begin
         fails++; $display("FAIL fill_empty: empty %b want 1", empty);
      end
   endtask

   task automatic test_full_pop_edge();
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      tests++;
      if (overflow !== 1'b0) begin
         fails++; $display("FAIL edge_clr0: ovf %b want 0", overflow);
      end
      for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
      wr_en = 1'b1; wr_data = 8'hEE; utx_ready = 1'b1;
      tick();
      wr_en = 1'b0; utx_ready = 1'b0;
      tests++;
      if (count !== 5'd15 || overflow !== 1'b1 || utx_data !== 8'h61) begin
         fails++;
         $display("FAIL edge_pushpop: count %0d ovf %b data %h want 15 1 61",
                  count, overflow, utx_data);
      end
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      tests++;
      if (overflow !== 1'b0) begin
         fails++; $display("FAIL edge_clr: ovf %b want 0", overflow);
      end
      push(8'h70);
      wr_en = 1'b1; wr_data = 8'hEF; ovf_clr = 1'b1;
      tick();
      wr_en = 1'b0; ovf_clr = 1'b0;
      tests++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         fails++; $display("FAIL edge_set_prio: ovf %b count %0d want 1 16", overflow, count);
      end
      utx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tests++;
         if (utx_data !== 8'h61 + 8'(i)) begin
            fails++;
            $display("FAIL edge_drain[%0d]: data %h want %h", i, utx_data, 8'h61 + 8'(i));
         end
         tick();
      end
      utx_ready = 1'b0;
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
   endtask

   task automatic test_wrap();
      logic [7:0] q[$];
      logic [7:0] nxt;
      logic       do_push, do_pop;
      nxt = 8'h80;
      for (int c = 0; c < 56; c++) begin
         wr_en     = (c < 40) && ($urandom_range(0, 9) < 7);
         wr_data   = nxt;
         utx_ready = (c >= 40) || ($urandom_range(0, 1) == 1);
         tests++;
         if (count !== 5'(q.size()) || count > 5'd16 || utx_valid !== (q.size() != 0) ||
             (q.size() != 0 && utx_data !== q[0])) begin
            fails++;
            $display("FAIL wrap[%0d]: count %0d valid %b data %h want %0d %b %h", c, count,
                     utx_valid, utx_data, q.size(), q.size() != 0,
                     (q.size() != 0) ? q[0] : 8'h00);
         end
         do_push = wr_en && (q.size() < 16);
         do_pop  = utx_ready && (q.size() != 0);
         tick();
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            q.push_back(nxt);
            nxt = nxt + 8'd1;
         end
      end
      wr_en = 1'b0; utx_ready = 1'b0;
      tests++;
      if (empty !== 1'b1 || q.size() != 0) begin
         fails++; $display("FAIL wrap_end: empty %b model %0d want 1 0", empty, q.size());
      end
   endtask

   task automatic test_latency();
      wr_en = 1'b1; wr_data = 8'h5A;
      #1;
      tests++;
      if (utx_valid !== 1'b0) begin
         fails++; $display("FAIL lat_bypass: valid %b want 0", utx_valid);
      end
      tick();
      wr_en = 1'b0;
      tests++;
      if (utx_valid !== 1'b1 || utx_data !== 8'h5A || count !== 5'd1) begin
         fails++;
         $display("FAIL lat_next: valid %b data %h count %0d want 1 5a 1",
                  utx_valid, utx_data, count);
      end
      utx_ready = 1'b1; tick(); utx_ready = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      for (int i = 0; i < 17; i++) push(8'hA0 + 8'(i));
      wr_en = 1'b1; wr_data = 8'hB5;
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({full, empty, count, utx_valid, overflow} !== {1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_async: full %b empty %b count %0d valid %b ovf %b want 0 1 0 0 0",
                  full, empty, count, utx_valid, overflow);
      end
      wr_en = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      utx_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         tests++;
         if (utx_valid !== 1'b0 || empty !== 1'b1) begin
            fails++; $display("FAIL reset_stale[%0d]: valid %b empty %b want 0 1",
                              i, utx_valid, empty);
         end
      end
      utx_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_burst();
      test_fill();
      test_full_pop_edge();
      test_wrap();
      test_latency();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
